// File: rtl/program_loader.sv
// Byte-serial boot loader: takes a framed stream (header, little-endian words,
// XOR checksum) and writes the words to program memory. The core stays stalled until the checksum matches.
module program_loader #(
  parameter int INSTR_WIDTH     = 31,
  parameter int ADDR_WIDTH      = 8,
  parameter int BYTES_PER_INSTR = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [7:0]             byte_in,
  input  logic                   byte_valid,
  output logic                   byte_ready,
  output logic                   pm_we,
  output logic [ADDR_WIDTH-1:0]  pm_addr,
  output logic [INSTR_WIDTH-1:0] pm_wdata,
  output logic                   core_hold,
  output logic                   done,
  output logic                   error,
  output logic [ADDR_WIDTH:0]    instr_count
);

  localparam int WORD_BITS = 8 * BYTES_PER_INSTR;
  localparam int IDX_W     = (BYTES_PER_INSTR > 1) ? $clog2(BYTES_PER_INSTR) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t                 state, state_next;
  logic [7:0]             hdr_n;
  logic [IDX_W-1:0]       byte_idx;
  logic [WORD_BITS-1:0]   word_buf;
  logic [WORD_BITS-1:0]   next_word;
  logic [ADDR_WIDTH-1:0]  word_idx;
  logic [ADDR_WIDTH-1:0]  last_idx;
  logic [7:0]             csum_acc;
  logic                   xfer;
  logic                   load_start;
  logic                   last_byte;
  logic                   word_overflow;

  assign xfer       = byte_valid & byte_ready;
  assign load_start = start & (state inside {S_IDLE, S_DONE, S_ERR});
  assign last_byte  = (byte_idx == IDX_W'(BYTES_PER_INSTR - 1));
  // Header 0 means a full 256-word frame; the modular subtraction yields 255.
  assign last_idx   = ADDR_WIDTH'(hdr_n) - ADDR_WIDTH'(1);

  // NOTE: every variable assigned in always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    next_word = word_buf;
    for (int i = 0; i < BYTES_PER_INSTR; i++) begin
      if (byte_idx == IDX_W'(i)) next_word[8*i +: 8] = byte_in;
    end
  end

  // Any stream bit above the instruction width marks a corrupt word.
  assign word_overflow = |(next_word >> INSTR_WIDTH);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE, S_DONE, S_ERR: if (start) state_next = S_HDR;
      S_HDR:   if (xfer) state_next = S_DATA;
      S_DATA:  if (xfer && last_byte) state_next = word_overflow ? S_ERR : S_WRITE;
      S_WRITE: state_next = (word_idx == last_idx) ? S_CSUM : S_DATA;
      S_CSUM:  if (xfer) state_next = (byte_in == csum_acc) ? S_DONE : S_ERR;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    byte_ready = 1'b0;
    pm_we      = 1'b0;
    pm_addr    = '0;
    pm_wdata   = '0;
    core_hold  = 1'b1;
    done       = 1'b0;
    error      = 1'b0;
    unique case (state)
      S_HDR, S_DATA, S_CSUM: byte_ready = 1'b1;
      S_WRITE: begin
        pm_we    = 1'b1;
        pm_addr  = word_idx;
        pm_wdata = word_buf[INSTR_WIDTH-1:0];
      end
      S_DONE: begin
        done      = 1'b1;
        core_hold = 1'b0;
      end
      S_ERR:   error = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hdr_n       <= '0;
      byte_idx    <= '0;
      word_buf    <= '0;
      word_idx    <= '0;
      csum_acc    <= '0;
      instr_count <= '0;
    end else begin
      if (load_start) begin
        byte_idx    <= '0;
        word_idx    <= '0;
        csum_acc    <= '0;
        instr_count <= '0;
      end
      if (state == S_HDR && xfer) hdr_n <= byte_in;
      if (state == S_DATA && xfer) begin
        word_buf <= next_word;
        csum_acc <= csum_acc ^ byte_in;
        byte_idx <= last_byte ? '0 : byte_idx + IDX_W'(1);
      end
      // Index wraps 255->0 only after the last word of a 256-word frame.
      if (state == S_WRITE) begin
        word_idx    <= word_idx + ADDR_WIDTH'(1);
        instr_count <= instr_count + (ADDR_WIDTH + 1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: good/bad-checksum frames, overflow word,
// a 256-word frame, stalls with ignored start pulses, and a mid-load reset.
module tb_program_loader;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        pm_we;
  logic [7:0]  pm_addr;
  logic [30:0] pm_wdata;
  logic        core_hold;
  logic        done;
  logic        error;
  logic [8:0]  instr_count;

  int compared = 0;
  int mismatched = 0;

  logic [7:0]  wr_addr_q[$];
  logic [30:0] wr_data_q[$];

  logic [7:0] f_good[$] = '{8'h02, 8'h02, 8'h32, 8'h00, 8'h00, 8'h23, 8'h01, 8'h00, 8'h00, 8'h12};
  logic [7:0] f_bad[$]  = '{8'h02, 8'h02, 8'h32, 8'h00, 8'h00, 8'h23, 8'h01, 8'h00, 8'h00, 8'h13};

  program_loader #(.INSTR_WIDTH(31), .ADDR_WIDTH(8), .BYTES_PER_INSTR(4)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .pm_we(pm_we),
    .pm_addr(pm_addr), .pm_wdata(pm_wdata), .core_hold(core_hold),
    .done(done), .error(error), .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (pm_we) begin
      wr_addr_q.push_back(pm_addr);
      wr_data_q.push_back(pm_wdata);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // All stimulus tasks start and end on a falling edge.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    while (!byte_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("byte_ready", {31'd0, byte_ready}, 32'd1);
    @(posedge clock);
    @(negedge clock);
    byte_valid = 1'b0;
  endtask

  task automatic check_two_writes(input string tag);
    check({tag, "_nwr"}, wr_addr_q.size(), 32'd2);
    if (wr_addr_q.size() == 2) begin
      check({tag, "_a0"}, {24'd0, wr_addr_q[0]}, 32'd0);
      check({tag, "_d0"}, {1'b0, wr_data_q[0]}, 32'h0000_3202);
      check({tag, "_a1"}, {24'd0, wr_addr_q[1]}, 32'd1);
      check({tag, "_d1"}, {1'b0, wr_data_q[1]}, 32'h0000_0123);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {31'd0, byte_ready}, 32'd0);
    check({tag, "_we"},    {31'd0, pm_we},      32'd0);
    check({tag, "_addr"},  {24'd0, pm_addr},    32'd0);
    check({tag, "_wdata"}, {1'b0, pm_wdata},    32'd0);
    check({tag, "_hold"},  {31'd0, core_hold},  32'd1);
    check({tag, "_done"},  {31'd0, done},       32'd0);
    check({tag, "_error"}, {31'd0, error},      32'd0);
    check({tag, "_count"}, {23'd0, instr_count}, 32'd0);
  endtask

  initial begin
    int bad_seq;

    // Reset values
    repeat (2) @(negedge clock);
    check_reset_outputs("rst");
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    check("idle_ready", {31'd0, byte_ready}, 32'd0);
    check("idle_hold",  {31'd0, core_hold},  32'd1);

    // Test 1: good N=2 frame, including write latency
    pulse_start();
    wr_addr_q.delete();
    wr_data_q.delete();
    check("t1_hdr_ready", {31'd0, byte_ready}, 32'd1);
    for (int i = 0; i < 5; i++) send_byte(f_good[i]);
    check("t1_we_latency", {31'd0, pm_we}, 32'd1);
    check("t1_we_addr",    {24'd0, pm_addr}, 32'd0);
    check("t1_we_data",    {1'b0, pm_wdata}, 32'h0000_3202);
    check("t1_we_noready", {31'd0, byte_ready}, 32'd0);
    for (int i = 5; i < 10; i++) send_byte(f_good[i]);
    check_two_writes("t1");
    check("t1_done",  {31'd0, done},  32'd1);
    check("t1_error", {31'd0, error}, 32'd0);
    check("t1_hold",  {31'd0, core_hold}, 32'd0);
    check("t1_count", {23'd0, instr_count}, 32'd2);

    // Test 2: same frame, bad checksum; restart from DONE
    pulse_start();
    wr_addr_q.delete();
    wr_data_q.delete();
    check("t2_done_clr", {31'd0, done}, 32'd0);
    check("t2_hold_set", {31'd0, core_hold}, 32'd1);
    check("t2_count_clr", {23'd0, instr_count}, 32'd0);
    foreach (f_bad[i]) send_byte(f_bad[i]);
    check_two_writes("t2");
    check("t2_error", {31'd0, error}, 32'd1);
    check("t2_done",  {31'd0, done},  32'd0);
    check("t2_hold",  {31'd0, core_hold}, 32'd1);
    check("t2_count", {23'd0, instr_count}, 32'd2);

    // Test 3: N=1 with word bit 31 set; restart from ERR
    pulse_start();
    wr_addr_q.delete();
    wr_data_q.delete();
    check("t3_err_clr", {31'd0, error}, 32'd0);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h80);
    check("t3_error_now", {31'd0, error}, 32'd1);
    check("t3_no_we",     {31'd0, pm_we}, 32'd0);
    byte_in    = 8'h80;
    byte_valid = 1'b1;
    repeat (5) @(negedge clock);
    check("t3_csum_refused", {31'd0, byte_ready}, 32'd0);
    byte_valid = 1'b0;
    check("t3_nwr",   wr_addr_q.size(), 32'd0);
    check("t3_error", {31'd0, error}, 32'd1);
    check("t3_hold",  {31'd0, core_hold}, 32'd1);
    check("t3_count", {23'd0, instr_count}, 32'd0);

    // Test 4: N=0 -> 256 zero words
    pulse_start();
    wr_addr_q.delete();
    wr_data_q.delete();
    send_byte(8'h00);
    for (int i = 0; i < 1024; i++) send_byte(8'h00);
    send_byte(8'h00);
    check("t4_nwr", wr_addr_q.size(), 32'd256);
    bad_seq = 0;
    foreach (wr_addr_q[i]) begin
      if (wr_addr_q[i] !== 8'(i) || wr_data_q[i] !== 31'd0) bad_seq++;
    end
    check("t4_addr_seq", bad_seq, 32'd0);
    check("t4_done",  {31'd0, done}, 32'd1);
    check("t4_count", {23'd0, instr_count}, 32'd256);

    // Test 5: N=2 frame with random gaps and ignored start pulses
    pulse_start();
    wr_addr_q.delete();
    wr_data_q.delete();
    pulse_start();
    foreach (f_good[i]) begin
      send_byte(f_good[i]);
      repeat ($urandom_range(0, 4)) @(negedge clock);
      if (i < f_good.size() - 1) pulse_start();
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end
    check_two_writes("t5");
    check("t5_done",  {31'd0, done}, 32'd1);
    check("t5_error", {31'd0, error}, 32'd0);
    check("t5_hold",  {31'd0, core_hold}, 32'd0);
    check("t5_count", {23'd0, instr_count}, 32'd2);

    // Test 6: reset during the 3rd data byte of word 1
    pulse_start();
    for (int i = 0; i < 7; i++) send_byte(f_good[i]);
    byte_in    = 8'h00;
    byte_valid = 1'b1;
    reset_n    = 1'b0;
    #1;
    check_reset_outputs("t6_rst");
    @(negedge clock);
    reset_n = 1'b1;
    wr_addr_q.delete();
    wr_data_q.delete();
    repeat (10) @(negedge clock);
    check("t6_idle_ready", {31'd0, byte_ready}, 32'd0);
    check("t6_no_write", wr_addr_q.size(), 32'd0);
    check("t6_hold",  {31'd0, core_hold}, 32'd1);
    check("t6_count", {23'd0, instr_count}, 32'd0);
    byte_valid = 1'b0;

    // Largest legal word after reset recovery: 0x7FFFFFFF, checksum 0x80
    pulse_start();
    send_byte(8'h01);
    send_byte(8'hFF);
    send_byte(8'hFF);
    send_byte(8'hFF);
    send_byte(8'h7F);
    check("t7_we",   {31'd0, pm_we}, 32'd1);
    check("t7_data", {1'b0, pm_wdata}, 32'h7FFF_FFFF);
    send_byte(8'h80);
    check("t7_done",  {31'd0, done}, 32'd1);
    check("t7_count", {23'd0, instr_count}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Byte-serial boot loader that sits directly upstream of the program memory and the control unit.
- Receives a framed byte stream over a valid/ready handshake and assembles 31-bit instruction words.
- Writes each word into program memory and verifies a trailing XOR checksum.
- Holds the processor core stalled until a load completes cleanly.

Parameters:
- INSTR_WIDTH, 31: instruction word width; must match the instruction decoder field layout.
- ADDR_WIDTH, 8: program memory address width (256 words).
- BYTES_PER_INSTR, 4: stream bytes per instruction, little-endian.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request to begin a load.
- byte_in  input  8  stream data byte.
- byte_valid  input  1  byte_in holds a valid byte.
- byte_ready  output  1  loader accepts byte_in this cycle.
- pm_we  output  1  program memory write strobe, one cycle per word.
- pm_addr  output  ADDR_WIDTH  program memory write address.
- pm_wdata  output  INSTR_WIDTH  assembled instruction word.
- core_hold  output  1  stalls the core (PC update and EUCL state machine) while high.
- done  output  1  load finished with a good checksum; level signal.
- error  output  1  load aborted; level signal.
- instr_count  output  ADDR_WIDTH+1  number of words written in the current/last load.

Behaviour:
- Reset (asynchronous, reset_n low):
  - state=IDLE; byte_ready=0, pm_we=0, pm_addr=0, pm_wdata=0.
  - core_hold=1: the core never runs an unloaded program.
  - done=0, error=0, instr_count=0; checksum accumulator and byte index cleared.
- A byte transfer occurs only on a cycle with byte_valid=1 and byte_ready=1. byte_in is ignored otherwise.
- byte_ready=1 only in HDR, DATA and CSUM. It is 0 in IDLE, WRITE, DONE and ERR.
- Frame format:
  - header byte N, where N=0 means 256 words;
  - then N×4 data bytes, LSB byte first;
  - then one checksum byte = XOR of all data bytes (header excluded).
- States:
  - IDLE: on start, go to HDR; core_hold=1; clear done, error, instr_count, accumulator.
  - HDR: on transfer, latch N; go to DATA.
  - DATA: on each transfer, place the byte into word lane [byte index] and XOR it into the accumulator.
    - On the 4th byte, bit 7 of that byte (word bit 31) must be 0. If it is 1, go to ERR and write nothing.
    - Otherwise go to WRITE.
  - WRITE: exactly one cycle with pm_we=1, pm_addr=word index, pm_wdata=assembled word[30:0].
    - Next cycle: instr_count += 1 and word index += 1.
    - If the last word was just written (index == N-1, or 255 when N=0), go to CSUM; else go to DATA.
  - CSUM: on transfer, compare byte_in to the accumulator.
    - Equal: go to DONE.
    - Not equal: go to ERR.
  - DONE: done=1, core_hold=0. start re-enters HDR (done cleared, core_hold=1 on the same edge).
  - ERR: error=1, core_hold=1. Exit only via start (re-enters HDR) or reset.
- start is ignored in HDR, DATA, WRITE and CSUM; it is not queued.
- Latency: pm_we asserts in the cycle after the 4th byte of a word is transferred. One word takes ≥5 cycles.
- Words already written before an error are not rolled back; instr_count reports how many were written.
- Word index wraps 255→0 only at N=256 end-of-frame. No write ever occurs beyond N words.
- Reset asserted mid-load aborts immediately. Nothing written after reset release; the partially written program is not trusted (core_hold=1).
- byte_valid gaps of any length are legal and stall the FSM without side effects.

Test Plan:
- Load N=2 with words 0x00003202, 0x00000123.
  - Stream: 02, 02,32,00,00, 23,01,00,00, 12.
  - Expect: pm_we at addr 0 data 0x00003202, then addr 1 data 0x00000123; done=1, core_hold=0, instr_count=2.
- Same frame with checksum 0x13.
  - Expect: both writes occur, then error=1, done=0, core_hold=1, instr_count=2.
- N=1, bytes 00,00,00,80.
  - Expect: no pm_we, error=1 immediately after the 4th byte; the checksum byte is never accepted (byte_ready=0).
- N=0 header with 1024 zero data bytes and checksum 00.
  - Expect: 256 writes at addresses 0..255, done=1, instr_count=256.
- Random byte_valid gaps and random start pulses mid-frame on the N=2 frame.
  - Expect: identical writes and result to the first test; start pulses have no effect.
- Assert reset_n low during the 3rd data byte of word 1, then release.
  - Expect: state IDLE, all outputs at reset values, no pm_we until the next start.
